sipo_shift_right: RTL and testbench

Serial-in, parallel-out shift register that shifts right. Each enabled clock edge loads one serial bit into the MSB and moves the existing contents one position toward the LSB. The full register is always visible on a parallel output. It sits at the front of a serial datapath, converting a 1-bit stream into WIDTH-bit words for downstream parallel logic.

---
 rtl/sipo_shift_right.sv | 25 ++
 tb/tb_sipo_shift_right.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_shift_right.sv
// Serial-in parallel-out shift register, shifting toward the LSB.
// New bits enter at the MSB; out mirrors the register flops.
module sipo_shift_right #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             inp,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (enb) begin
      q <= {inp, q[WIDTH-1:1]};
    end
  end

  assign out = q;

endmodule

// File: tb/tb_sipo_shift_right.sv
// Directed bench for sipo_shift_right.
// Runs a 4-bit and an 8-bit instance from shared stimulus.
module tb_sipo_shift_right;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       inp;
  logic [3:0] out4;
  logic [7:0] out8;

  int n_cmp;
  int n_bad;

  sipo_shift_right #(.WIDTH(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .inp(inp),
    .out(out4)
  );

  sipo_shift_right #(.WIDTH(8)) dut8 (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .inp(inp),
    .out(out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, return at the falling edge.
  task automatic tick(input logic e, input logic i);
    enb = e;
    inp = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, c[0]);
      n_cmp++;
      if (out4 !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_hold4 c=%0d got=%b exp=0000", c, out4);
      end
      n_cmp++;
      if (out8 !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_hold8 c=%0d got=%b exp=00000000", c, out8);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (out4 !== 4'b0000) begin
        n_bad++;
        $display("FAIL release_hold c=%0d got=%b exp=0000", c, out4);
      end
    end
  endtask

  task automatic test_basic_shift;
    logic       bits [4];
    logic [3:0] exp  [4];
    bits = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp  = '{4'b1000, 4'b0100, 4'b1010, 4'b0101};
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, bits[k]);
      n_cmp++;
      if (out4 !== exp[k]) begin
        n_bad++;
        $display("FAIL basic_shift k=%0d got=%b exp=%b", k, out4, exp[k]);
      end
    end
  endtask

  task automatic test_enable_gating;
    tick(1'b1, 1'b1);
    n_cmp++;
    if (out4 !== 4'b1010) begin
      n_bad++;
      $display("FAIL gate_setup got=%b exp=1010", out4);
    end
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b1);
      n_cmp++;
      if (out4 !== 4'b1010) begin
        n_bad++;
        $display("FAIL gate_hold k=%0d got=%b exp=1010", k, out4);
      end
    end
    tick(1'b1, 1'b1);
    n_cmp++;
    if (out4 !== 4'b1101) begin
      n_bad++;
      $display("FAIL gate_resume got=%b exp=1101", out4);
    end
  endtask

  task automatic test_fill;
    logic [3:0] exp [8];
    exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
            4'b0111, 4'b0011, 4'b0001, 4'b0000};
    rst = 1'b0;
    #1;
    rst = 1'b1;
    n_cmp++;
    if (out4 !== 4'b0000) begin
      n_bad++;
      $display("FAIL fill_start got=%b exp=0000", out4);
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, (k < 4) ? 1'b1 : 1'b0);
      n_cmp++;
      if (out4 !== exp[k]) begin
        n_bad++;
        $display("FAIL fill k=%0d got=%b exp=%b", k, out4, exp[k]);
      end
    end
  endtask

  task automatic test_async_reset;
    logic bits [4];
    bits = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) tick(1'b1, bits[k]);
    n_cmp++;
    if (out4 !== 4'b1011) begin
      n_bad++;
      $display("FAIL async_setup got=%b exp=1011", out4);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out4 !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_assert got=%b exp=0000", out4);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if (out4 !== 4'b0000) begin
        n_bad++;
        $display("FAIL async_held k=%0d got=%b exp=0000", k, out4);
      end
    end
    rst = 1'b1;
    tick(1'b1, 1'b1);
    n_cmp++;
    if (out4 !== 4'b1000) begin
      n_bad++;
      $display("FAIL async_release got=%b exp=1000", out4);
    end
  endtask

  task automatic test_width8;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick(1'b1, 1'b1);
    n_cmp++;
    if (out8 !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL w8_edge1 got=%b exp=10000000", out8);
    end
    for (int k = 2; k <= 8; k++) tick(1'b1, 1'b0);
    n_cmp++;
    if (out8 !== 8'b0000_0001) begin
      n_bad++;
      $display("FAIL w8_edge8 got=%b exp=00000001", out8);
    end
    tick(1'b1, 1'b0);
    n_cmp++;
    if (out8 !== 8'b0000_0000) begin
      n_bad++;
      $display("FAIL w8_drop got=%b exp=00000000", out8);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    enb = 1'b0;
    inp = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_shift();
    test_enable_gating();
    test_fill();
    test_async_reset();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
